// File: rtl/mem_datos_param.sv
// rtl/mem_datos_param.sv - clocked byte-lane data memory with registered read, handshake and error counting
//
// Optional feature macro: MEMDATOS_CLEAR_EN (zero-fills the array after reset before accepting requests).
//
// Ports:
//   clk       in   1         single clock, rising edge
//   rst_n     in   1         asynchronous active-low reset
//   req       in   1         access request, accepted when ready=1
//   we        in   1         write strobe (store)
//   re        in   1         read strobe (load)
//   addr      in   ADDR_W    word address
//   data_in   in   DATA_W    store data
//   be        in   BE_W      byte-lane write enables
//   ready     out  1         block accepts a request this cycle
//   rvalid    out  1         one-cycle pulse, data_out holds read result
//   data_out  out  DATA_W    load data, held between reads
//   err       out  1         one-cycle pulse, previous accepted request was illegal
//   err_cnt   out  ERRCNT_W  saturating count of illegal requests

module mem_datos_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 120,
    parameter int ADDR_W   = 7,
    parameter int ERRCNT_W = 8,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [BE_W-1:0]     be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   data_out,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              acc;
    logic              in_range;
    logic              both;
    logic              illegal;
    logic              wr_ok;
    logic              rd_acc;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    assign acc      = req & ready;
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign both     = we & re;
    assign illegal  = both | ((we | re) & ~in_range);
    assign wr_ok    = acc & we & ~re & in_range;
    // Any accepted pure read pulses rvalid, including out-of-range ones.
    assign rd_acc   = acc & re & ~we;

`ifdef MEMDATOS_CLEAR_EN
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              ready_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            ready   <= ready_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        ready_nx   = 1'b0;
        clr_we     = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we = 1'b1;
                if ({1'b0, clr_cnt} == DEPTH_L - 1'b1) begin
                    // Last word is zeroed on this edge; ready follows it.
                    state_nx   = S_IDLE;
                    clr_cnt_nx = '0;
                    ready_nx   = 1'b1;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                ready_nx = 1'b1;
            end
        endcase
    end

    assign clr_addr = clr_cnt;
`else
    // Without the clear sweep, ready comes up on the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Array has no reset; clear writes and accepted writes never overlap
    // because ready is low for the whole sweep.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid   <= 1'b0;
            data_out <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            rvalid <= rd_acc;
            err    <= acc & illegal;
            if (rd_acc) begin
                data_out <= in_range ? mem[addr] : '0;
            end
            if (acc && illegal && (err_cnt != {ERRCNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_datos_param.sv
// tb/tb_mem_datos_param.sv - self-checking bench for mem_datos_param with a behavioural memory model
module tb_mem_datos_param;

    localparam int DEPTH = 120;
`ifdef MEMDATOS_CLEAR_EN
    localparam int READY_LAT = 120;
`else
    localparam int READY_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  be = '0;
    logic        ready;
    logic        rvalid;
    logic [31:0] data_out;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem_m [0:DEPTH-1];
    logic        exp_rvalid = 1'b0;
    logic [31:0] exp_dout = '0;
    logic        exp_err = 1'b0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    mem_datos_param dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .re(re),
        .addr(addr), .data_in(data_in), .be(be),
        .ready(ready), .rvalid(rvalid), .data_out(data_out),
        .err(err), .err_cnt(err_cnt)
    );

    function automatic void model_reset();
        exp_rvalid = 1'b0;
        exp_dout   = '0;
        exp_err    = 1'b0;
        exp_cnt    = 0;
`ifdef MEMDATOS_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
`endif
    endfunction

    function automatic void model_step(input logic r, input logic w, input logic rd,
                                       input int a, input logic [31:0] d, input logic [3:0] b);
        logic bad;
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        if (!r) return;
        bad = (w && rd) || ((w || rd) && a >= DEPTH);
        exp_err    = bad;
        exp_rvalid = rd && !w;
        if (rd && !w) begin
            exp_dout = (a < DEPTH) ? mem_m[a] : 32'h0;
        end else if (w && !rd && a < DEPTH) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
        end
        if (bad && exp_cnt < 255) exp_cnt = exp_cnt + 1;
    endfunction

    // Drives one cycle of stimulus, advances past the edge, updates the model.
    task automatic issue(input logic r, input logic w, input logic rd,
                         input int a, input logic [31:0] d, input logic [3:0] b);
        req = r; we = w; re = rd; addr = a[6:0]; data_in = d; be = b;
        @(posedge clk); #1;
        model_step(r, w, rd, a, d, b);
        req = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, rvalid, err, data_out, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b rvalid=%0b err=%0b data_out=%h err_cnt=%0d, required all 0",
                     ready, rvalid, err, data_out, err_cnt);
        end
        rst_n = 1'b1;
        model_reset();
        wait_ready(n);
        checks++;
        if (n !== READY_LAT) begin
            errors++;
            $display("FAIL ready_latency: got %0d cycles, required %0d", n, READY_LAT);
        end
    endtask

    task automatic test_clear_read();
`ifndef MEMDATOS_CLEAR_EN
        issue(1, 1, 0, 119, 32'h0, 4'hF);
`endif
        issue(1, 0, 1, 119, 32'h0, 4'h0);
        checks++;
        if (rvalid !== 1'b1 || data_out !== exp_dout || exp_dout !== 32'h0) begin
            errors++;
            $display("FAIL clear_read119: rvalid=%0b data_out=%h, required rvalid=1 data_out=%h",
                     rvalid, data_out, exp_dout);
        end
    endtask

    task automatic test_byte_lanes();
        issue(1, 1, 0, 5, 32'hAABBCCDD, 4'b1111);
        issue(1, 1, 0, 5, 32'h11223344, 4'b0101);
        issue(1, 0, 1, 5, 32'h0, 4'h0);
        checks++;
        if (rvalid !== 1'b1 || data_out !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_lanes: rvalid=%0b data_out=%h, required 1 / aa22cc44", rvalid, data_out);
        end
        issue(1, 1, 0, 5, 32'hFFFFFFFF, 4'b0000);
        issue(1, 0, 1, 5, 32'h0, 4'h0);
        checks++;
        if (data_out !== exp_dout || err !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_noop: data_out=%h err=%0b, required %h / 0", data_out, err, exp_dout);
        end
    endtask

    task automatic test_back_to_back();
        issue(1, 1, 0, 3, 32'h12345678, 4'hF);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_write_rvalid: rvalid=%0b, required 0", rvalid);
        end
        issue(1, 0, 1, 3, 32'h0, 4'h0);
        checks++;
        if (rvalid !== 1'b1 || data_out !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_read: rvalid=%0b data_out=%h, required 1 / 12345678", rvalid, data_out);
        end
        @(posedge clk); #1;
        model_step(0, 0, 0, 0, 0, 0);
        checks++;
        if (rvalid !== 1'b0 || data_out !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_pulse_hold: rvalid=%0b data_out=%h, required 0 / 12345678", rvalid, data_out);
        end
    endtask

    task automatic test_illegal_both();
        issue(1, 1, 0, 7, 32'hCAFEF00D, 4'hF);
        issue(1, 1, 1, 7, 32'h0BADBEEF, 4'hF);
        checks++;
        if (err !== 1'b1 || rvalid !== 1'b0 || err_cnt !== 8'd1 || data_out !== exp_dout) begin
            errors++;
            $display("FAIL illegal_we_re: err=%0b rvalid=%0b err_cnt=%0d data_out=%h, required 1/0/1/%h",
                     err, rvalid, err_cnt, data_out, exp_dout);
        end
        issue(1, 0, 1, 7, 32'h0, 4'h0);
        checks++;
        if (data_out !== 32'hCAFEF00D || err !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_mem_kept: data_out=%h err=%0b rvalid=%0b, required cafef00d/0/1",
                     data_out, err, rvalid);
        end
    endtask

    task automatic test_out_of_range();
        issue(1, 0, 1, 120, 32'h0, 4'h0);
        checks++;
        if (rvalid !== 1'b1 || data_out !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: rvalid=%0b data_out=%h err=%0b, required 1/0/1", rvalid, data_out, err);
        end
        issue(1, 1, 0, 127, 32'hDEADBEEF, 4'hF);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd3 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oor_write: err=%0b err_cnt=%0d rvalid=%0b, required 1/3/0", err, err_cnt, rvalid);
        end
        issue(1, 0, 0, 9, 32'h0, 4'h0);
        checks++;
        if (err !== 1'b0 || rvalid !== 1'b0 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL idle_req: err=%0b rvalid=%0b err_cnt=%0d, required 0/0/3", err, rvalid, err_cnt);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < DEPTH; a++) issue(1, 1, 0, a, $urandom, 4'hF);
        for (int k = 0; k < 300; k++) begin
            int op = $urandom_range(0, 9);
            int a  = ($urandom_range(0, 9) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 119);
            logic r = ($urandom_range(0, 4) != 0);
            case (op)
                0, 1, 2, 3: issue(r, 1, 0, a, $urandom, 4'($urandom));
                4, 5, 6, 7: issue(r, 0, 1, a, 32'h0, 4'h0);
                8:          issue(r, 0, 0, a, 32'h0, 4'h0);
                default:    issue(r, 1, 1, a, $urandom, 4'hF);
            endcase
            checks++;
            if (rvalid !== exp_rvalid || err !== exp_err || data_out !== exp_dout || err_cnt !== exp_cnt[7:0]) begin
                errors++;
                $display("FAIL random[%0d]: rvalid=%0b err=%0b data_out=%h err_cnt=%0d, required %0b/%0b/%h/%0d",
                         k, rvalid, err, data_out, err_cnt, exp_rvalid, exp_err, exp_dout, exp_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) issue(1, 1, 1, $urandom_range(0, 127), 32'h0, 4'hF);
        checks++;
        if (err_cnt !== 8'd255 || exp_cnt != 255) begin
            errors++;
            $display("FAIL err_cnt_saturate: err_cnt=%0d, required 255", err_cnt);
        end
        issue(1, 0, 1, 200 - 80, 32'h0, 4'h0);
        checks++;
        if (err_cnt !== 8'd255 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_cnt_hold: err_cnt=%0d err=%0b, required 255/1", err_cnt, err);
        end
    endtask

`ifdef MEMDATOS_CLEAR_EN
    task automatic test_reset_mid_clear();
        int n;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_ready: ready=%0b, required 0", ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, rvalid, err, data_out, err_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_clear_reset_outputs: ready=%0b rvalid=%0b err=%0b data_out=%h err_cnt=%0d, required all 0",
                     ready, rvalid, err, data_out, err_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        wait_ready(n);
        checks++;
        if (n !== 120) begin
            errors++;
            $display("FAIL mid_clear_restart: ready after %0d cycles, required 120", n);
        end
        issue(1, 0, 1, 60, 32'h0, 4'h0);
        checks++;
        if (data_out !== 32'h0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_word60: data_out=%h rvalid=%0b, required 0/1", data_out, rvalid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clear_read();
        test_byte_lanes();
        test_back_to_back();
        test_illegal_both();
        test_out_of_range();
        test_random();
        test_saturation();
`ifdef MEMDATOS_CLEAR_EN
        test_reset_mid_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_datos_param.md
Name: mem_datos_param

Overview:
- Parametrised synchronous data memory for the single-cycle datapath.
- Next generation of the existing unclocked data memory: clocked, byte-lane writes, registered read with valid pulse, request/ready handshake.
- Detects illegal accesses (simultaneous write+read, out-of-range address) and counts them.
- Sits between the ALU result/register-file read port (address/store data) and the write-back multiplexer (load data).

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8. Derived BE_W = DATA_W/8.
- DEPTH, 120, number of words.
- ADDR_W, 7, word-address width; 2**ADDR_W >= DEPTH required.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request, qualified by ready.
- we  in  1  write strobe (store); we and re must not both be 1.
- re  in  1  read strobe (load).
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  store data.
- be  in  BE_W  byte-lane enables for writes; be[i] selects data_in[8i+7:8i].
- ready  out  1  block accepts a request this cycle.
- rvalid  out  1  one-cycle pulse: data_out holds read result.
- data_out  out  DATA_W  load data, held between reads.
- err  out  1  one-cycle pulse: previous accepted request was illegal.
- err_cnt  out  ERRCNT_W  saturating count of illegal requests.

Behaviour:
- Reset (rst_n=0, async): ready=0, rvalid=0, data_out=0, err=0, err_cnt=0, FSM -> CLEAR (feature on) or IDLE (feature off). Memory array is not reset asynchronously.
- Accept: a request is accepted on a rising edge where req=1 and ready=1. req with ready=0 is ignored; it is neither stalled nor queued.
- FSM states: CLEAR -> IDLE. In IDLE, ready=1 every cycle, so back-to-back accesses are allowed.
- Legal write (we=1, re=0, addr<DEPTH): lanes with be[i]=1 are updated at the accept edge; other lanes are unchanged. No rvalid. be=0 is a legal no-op.
- Legal read (re=1, we=0, addr<DEPTH): latency 1. At accept edge T, data_out <= mem[addr] and rvalid=1 during cycle T+1 only. A read at T following a write at T-1 to the same address returns the written data.
- Idle request (req=1, we=0, re=0): no effect, no error.
- Illegal, we=1 and re=1: memory unchanged; rvalid=0; data_out held; err=1 at T+1.
- Illegal, addr>=DEPTH:
  - Write: discarded, err=1.
  - Read: data_out <= 0, rvalid=1 and err=1 at T+1.
- err_cnt increments by 1 per illegal accepted request and saturates at 2**ERRCNT_W-1.
- data_out changes only on a legal or out-of-range read.

Optional Feature:
- Macro: MEMDATOS_CLEAR_EN.
- Defined:
  - After rst_n deasserts, the FSM stays in CLEAR for DEPTH cycles, writing 0 to words 0..DEPTH-1 using an internal ADDR_W counter.
  - ready=0 throughout CLEAR; ready rises in the cycle after word DEPTH-1 is written.
  - Reset asserted mid-clear restarts the clear from word 0.
- Undefined:
  - No CLEAR state; ready=1 from the first edge after reset deassertion.
  - Memory contents are undefined until written.

Test Plan:
- Clear (feature on): release reset -> ready=0 for exactly 120 cycles, then 1. Read addr 119 -> rvalid at T+1, data_out=0x00000000.
- Byte lanes: write 0xAABBCCDD be=4'b1111 to addr 5, then 0x11223344 be=4'b0101 to addr 5, read addr 5 -> data_out=0xAA22CC44 at T+1.
- Back-to-back: write addr 3 = 0x12345678, read addr 3 on the very next cycle -> data_out=0x12345678, rvalid exactly one cycle.
- Illegal we+re at addr 7 holding 0xCAFEF00D -> err=1 at T+1, rvalid=0, err_cnt=1, subsequent read of addr 7 = 0xCAFEF00D.
- Out of range: read addr 120 -> rvalid=1, data_out=0, err=1. Write addr 127 -> err=1, err_cnt=3. Force 300 illegal requests -> err_cnt saturates at 255.
- Reset mid-clear: assert rst_n=0 after 50 clear cycles, release -> ready stays 0 for a full 120 cycles; all outputs 0 while reset is asserted.
